// File: rtl/lock_code_sender_if.sv
// Sequencer- and lock-facing signals of lock_code_sender; master is the sender, slave its environment.
// tried_o widens when LOCK_SENDER_RETRY_EN is defined because every code may be pressed twice.
interface lock_code_sender_if #(
  parameter int DIGITS = 4
);
`ifdef LOCK_SENDER_RETRY_EN
  localparam int TW = $clog2(2 * DIGITS + 1);
`else
  localparam int TW = $clog2(DIGITS + 1);
`endif

  logic                  start_i;
  logic                  mode_i;
  logic [4*DIGITS-1:0]   code_i;
  logic                  alarm_i;
  logic                  open_i;
  logic                  new_i;
  logic [3:0]            x_o;
  logic                  enter_o;
  logic                  change_o;
  logic                  busy_o;
  logic                  done_o;
  logic [1:0]            result_o;
  logic [TW-1:0]         tried_o;

  modport master (
    input  start_i, mode_i, code_i, alarm_i, open_i, new_i,
    output x_o, enter_o, change_o, busy_o, done_o, result_o, tried_o
  );

  modport slave (
    output start_i, mode_i, code_i, alarm_i, open_i, new_i,
    input  x_o, enter_o, change_o, busy_o, done_o, result_o, tried_o
  );
endinterface

// File: rtl/lock_code_sender.sv
// Key-entry initiator for the combination lock: presses candidate codes or programs a new one (option LOCK_SENDER_RETRY_EN).
// Latency per code HOLD+PRESS+RESP cycles; start while busy is dropped, no backpressure from the lock.
module lock_code_sender #(
  parameter int DIGITS       = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int PRESS_CYCLES = 3,
  parameter int RESP_CYCLES  = 16
) (
  input logic               clock_i,
  input logic               reset_i,
  lock_code_sender_if.master bus
);
`ifdef LOCK_SENDER_RETRY_EN
  localparam int TW = $clog2(2 * DIGITS + 1);
`else
  localparam int TW = $clog2(DIGITS + 1);
`endif
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMX1 = (HOLD_CYCLES > PRESS_CYCLES) ? HOLD_CYCLES : PRESS_CYCLES;
  localparam int CMAX = (CMX1 > RESP_CYCLES) ? CMX1 : RESP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PRESS, S_WAIT, S_CHG_PRESS, S_CHG_WAIT, S_DONE
  } state_t;

  state_t                 state_q;
  logic                   mode_q;
  logic [DIGITS-1:0][3:0] codes_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic [CW-1:0]          cnt_q;
  logic [3:0]             x_q;
  logic                   enter_q;
  logic                   change_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             result_q;
  logic [TW-1:0]          tried_q;
`ifdef LOCK_SENDER_RETRY_EN
  logic                   retried_q;
`endif

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      codes_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      x_q       <= 4'h0;
      enter_q   <= 1'b0;
      change_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 2'b00;
      tried_q   <= '0;
`ifdef LOCK_SENDER_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            mode_q    <= bus.mode_i;
            codes_q   <= bus.code_i;
            idx_q     <= '0;
            tried_q   <= '0;
            busy_q    <= 1'b1;
`ifdef LOCK_SENDER_RETRY_EN
            retried_q <= 1'b0;
`endif
            if (bus.mode_i) begin
              state_q  <= S_CHG_PRESS;
              x_q      <= 4'h0;
              change_q <= 1'b1;
              cnt_q    <= CW'(PRESS_CYCLES - 1);
            end else begin
              state_q <= S_SETUP;
              x_q     <= bus.code_i[3:0];
              cnt_q   <= CW'(HOLD_CYCLES - 1);
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_PRESS;
            enter_q <= 1'b1;
            tried_q <= tried_q + 1'b1;
            cnt_q   <= CW'(PRESS_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PRESS: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT;
            enter_q <= 1'b0;
            cnt_q   <= CW'(RESP_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          // Alarm outranks every other status seen in the same cycle
          if (bus.alarm_i) begin
            state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b01;
          end else if (!mode_q && bus.open_i) begin
            state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b11;
          end else if (mode_q && !bus.new_i) begin
            state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b10;
          end else if (cnt_q == '0) begin
`ifdef LOCK_SENDER_RETRY_EN
            if (!retried_q) begin
              retried_q <= 1'b1;
              state_q   <= S_SETUP;
              cnt_q     <= CW'(HOLD_CYCLES - 1);
            end else
`endif
            if (!mode_q && idx_q != LAST) begin
              idx_q   <= idx_d;
              x_q     <= codes_q[idx_d];
              state_q <= S_SETUP;
              cnt_q   <= CW'(HOLD_CYCLES - 1);
`ifdef LOCK_SENDER_RETRY_EN
              retried_q <= 1'b0;
`endif
            end else begin
              state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b00;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHG_PRESS: begin
          if (cnt_q == '0) begin
            state_q  <= S_CHG_WAIT;
            change_q <= 1'b0;
            cnt_q    <= CW'(RESP_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHG_WAIT: begin
          if (bus.alarm_i) begin
            state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b01;
          end else if (bus.new_i) begin
            // Lock now accepts the new combination: enter code 0 through the normal press path
            state_q <= S_SETUP;
            idx_q   <= '0;
            x_q     <= codes_q[0];
            cnt_q   <= CW'(HOLD_CYCLES - 1);
`ifdef LOCK_SENDER_RETRY_EN
            retried_q <= 1'b0;
`endif
          end else if (cnt_q == '0) begin
`ifdef LOCK_SENDER_RETRY_EN
            if (!retried_q) begin
              retried_q <= 1'b1;
              state_q   <= S_CHG_PRESS;
              change_q  <= 1'b1;
              cnt_q     <= CW'(PRESS_CYCLES - 1);
            end else
`endif
            begin
              state_q <= S_DONE; done_q <= 1'b1; busy_q <= 1'b0; result_q <= 2'b00;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x_o      = x_q;
  assign bus.enter_o  = enter_q;
  assign bus.change_o = change_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.tried_o  = tried_q;
endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: behavioural lock model plus a scoreboard of expected outcomes per transaction.
module tb_lock_code_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lock_code_sender_if #(.DIGITS(4)) bus ();

  lock_code_sender #(
    .DIGITS(4), .HOLD_CYCLES(4), .PRESS_CYCLES(3), .RESP_CYCLES(16)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] res;
    int         tried;
    logic [3:0] x;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lock model: 0 opens on matching code, 1 raises alarm and open together, 2 new-combination flow
  int         lk_mode  = 0;
  logic [3:0] lk_combo = 4'h0;
  bit         lk_clr   = 1'b1;
  logic       en_prev  = 1'b0;
  logic       ch_prev  = 1'b0;

  always @(posedge clk) begin
    en_prev <= bus.enter_o;
    ch_prev <= bus.change_o;
    if (lk_clr) begin
      bus.alarm_i <= 1'b0;
      bus.open_i  <= 1'b0;
      bus.new_i   <= 1'b0;
    end else begin
      if (ch_prev && !bus.change_o && lk_mode == 2) bus.new_i <= 1'b1;
      if (en_prev && !bus.enter_o) begin
        if (lk_mode == 0 && bus.x_o == lk_combo) bus.open_i <= 1'b1;
        if (lk_mode == 1) begin
          bus.alarm_i <= 1'b1;
          bus.open_i  <= 1'b1;
        end
        if (lk_mode == 2) bus.new_i <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (bus.enter_o || bus.change_o))
      check_val("btn_exclusive", {31'd0, bus.enter_o & bus.change_o}, 32'd0);
    if (!rst && bus.done_o) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("result", {30'd0, bus.result_o}, {30'd0, e.res});
        check_val("tried", 32'(bus.tried_o), 32'(e.tried));
        check_val("x_at_done", {28'd0, bus.x_o}, {28'd0, e.x});
        check_val("busy_at_done", {31'd0, bus.busy_o}, 32'd0);
        check_val("btn_at_done", {30'd0, bus.enter_o, bus.change_o}, 32'd0);
      end
    end
  end

  task automatic run_txn(input logic m, input logic [15:0] code, input int lkm,
                         input logic [3:0] combo, input logic [1:0] er, input int et,
                         input logic [3:0] ex, input int ecyc, input bit glitch);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    lk_clr = 1'b1;
    @(negedge clk);
    lk_clr   = 1'b0;
    lk_mode  = lkm;
    lk_combo = combo;
    e.res = er; e.tried = et; e.x = ex;
    sb_q.push_back(e);
    bus.mode_i  = m;
    bus.code_i  = code;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    seen = 1'b0;
    for (n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) check_val("busy_after_start", {31'd0, bus.busy_o}, 32'd1);
      if (glitch && n == 10) begin
        bus.start_i = 1'b1;
        bus.mode_i  = ~m;
        bus.code_i  = 16'h9999;
      end else if (glitch && n == 11) begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("done_within_bound", {31'd0, seen}, 32'd1);
    if (seen && ecyc > 0) check_val("done_latency", 32'(n), 32'(ecyc));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.code_i  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_val("rst_done", {31'd0, bus.done_o}, 32'd0);
    check_val("rst_result", {30'd0, bus.result_o}, 32'd0);
    check_val("rst_tried", 32'(bus.tried_o), 32'd0);
    check_val("rst_x", {28'd0, bus.x_o}, 32'd0);
    check_val("rst_btn", {30'd0, bus.enter_o, bus.change_o}, 32'd0);
    rst = 1'b0;

    // Reset held two cycles in the middle of a press
    @(negedge clk);
    lk_clr = 1'b0; lk_mode = 0; lk_combo = 4'hF;
    bus.mode_i = 1'b0; bus.code_i = 16'h5A37; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.enter_o) break;
    end
    check_val("press_reached", {31'd0, bus.enter_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_enter", {31'd0, bus.enter_o}, 32'd0);
    check_val("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check_val("midrst_result", {30'd0, bus.result_o}, 32'd0);
    check_val("midrst_tried", 32'(bus.tried_o), 32'd0);
    check_val("midrst_x", {28'd0, bus.x_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("postrst_busy", {31'd0, bus.busy_o}, 32'd0);

`ifdef LOCK_SENDER_RETRY_EN
    run_txn(1'b0, 16'h5A37, 0, 4'h3, 2'b11, 3, 4'h3, -1, 1'b0);
    run_txn(1'b0, 16'h1111, 0, 4'h9, 2'b00, 8, 4'h1, 185, 1'b1);
    run_txn(1'b0, 16'h3000, 0, 4'h3, 2'b11, 7, 4'h3, -1, 1'b0);
    run_txn(1'b1, 16'h000C, 0, 4'h0, 2'b00, 0, 4'h0, 39, 1'b0);
`else
    run_txn(1'b0, 16'h5A37, 0, 4'h3, 2'b11, 2, 4'h3, -1, 1'b0);
    run_txn(1'b0, 16'h1111, 0, 4'h9, 2'b00, 4, 4'h1, 93, 1'b1);
    run_txn(1'b0, 16'h3000, 0, 4'h3, 2'b11, 4, 4'h3, -1, 1'b0);
    run_txn(1'b1, 16'h000C, 0, 4'h0, 2'b00, 0, 4'h0, 20, 1'b0);
`endif
    run_txn(1'b0, 16'h0002, 1, 4'h2, 2'b01, 1, 4'h2, -1, 1'b0);
    run_txn(1'b1, 16'h000C, 2, 4'h0, 2'b10, 1, 4'hC, -1, 1'b0);

    repeat (4) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
